// File: rtl/snax_acc_csr_manager.sv
// CSR manager between a core req/rsp port and the accelerator-side config interface.
// The core programs staged RW registers; a LAUNCH write copies them to the committed
// set and offers it to the accelerator with a valid/ready handshake.
module snax_acc_csr_manager #(
   parameter int unsigned RegRWCount   = 2,
   parameter int unsigned RegROCount   = 2,
   parameter int unsigned RegDataWidth = 32,
   parameter int unsigned RegAddrWidth = 32
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  logic [RegAddrWidth-1:0]            csr_req_addr_i,
   input  logic [RegDataWidth-1:0]            csr_req_data_i,
   input  logic                               csr_req_write_i,
   input  logic                               csr_req_valid_i,
   output logic                               csr_req_ready_o,
   output logic [RegDataWidth-1:0]            csr_rsp_data_o,
   output logic                               csr_rsp_valid_o,
   input  logic                               csr_rsp_ready_i,
   output logic [RegRWCount*RegDataWidth-1:0] csr_reg_set_o,
   output logic                               csr_reg_set_valid_o,
   input  logic                               csr_reg_set_ready_i,
   input  logic [RegROCount*RegDataWidth-1:0] csr_reg_ro_set_i
);

   localparam int unsigned LaunchAddr = RegRWCount + RegROCount;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PEND = 1'b1
   } state_e;

   state_e                  r_state;
   state_e                  w_state_nxt;
   logic [RegDataWidth-1:0] r_staged [RegRWCount];
   logic [RegDataWidth-1:0] r_commit [RegRWCount];
   logic                    r_rsp_valid;
   logic [RegDataWidth-1:0] r_rsp_data;

   logic                    w_is_launch_req;
   logic                    w_rsp_stall;
   logic                    w_req_ready;
   logic                    w_accept;
   logic                    w_wr;
   logic                    w_rd;
   logic                    w_launch_go;
   logic                    w_set_valid;
   logic [RegDataWidth-1:0] w_rd_data;

   // A launch request that would start a new job (data bit 0 set)
   assign w_is_launch_req = csr_req_valid_i & csr_req_write_i & csr_req_data_i[0] &
                            (csr_req_addr_i == RegAddrWidth'(LaunchAddr));

   // Hold off all requests while a read response waits; hold off a second launch while pending
   assign w_rsp_stall = r_rsp_valid & ~csr_rsp_ready_i;
   assign w_req_ready = ~w_rsp_stall & ~((r_state == ST_PEND) & w_is_launch_req);

   assign w_accept    = csr_req_valid_i & w_req_ready;
   assign w_wr        = w_accept & csr_req_write_i;
   assign w_rd        = w_accept & ~csr_req_write_i;
   assign w_launch_go = w_wr & w_is_launch_req & (r_state == ST_IDLE);

   // Launch FSM state register
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Launch FSM next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_launch_go)         w_state_nxt = ST_PEND;
         ST_PEND: if (csr_reg_set_ready_i) w_state_nxt = ST_IDLE;
         default:                          w_state_nxt = ST_IDLE;
      endcase
   end

   // Launch FSM outputs: valid is a pure decode of the state register
   always_comb begin
      w_set_valid = 1'b0;
      if (r_state == ST_PEND) w_set_valid = 1'b1;
   end

   // Staged RW registers, written on accept in any launch state
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < RegRWCount; i++) r_staged[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < RegRWCount; i++) begin
            if (w_wr && (csr_req_addr_i == RegAddrWidth'(i))) r_staged[i] <= csr_req_data_i;
         end
      end
   end

   // Committed set, snapshotted from staging when a launch starts
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < RegRWCount; i++) r_commit[i] <= '0;
      end else if (w_launch_go) begin
         for (int unsigned i = 0; i < RegRWCount; i++) r_commit[i] <= r_staged[i];
      end
   end

   // Read mux over the address map; unmapped addresses read as zero
   always_comb begin
      w_rd_data = '0;
      for (int unsigned i = 0; i < RegRWCount; i++) begin
         if (csr_req_addr_i == RegAddrWidth'(i)) w_rd_data = r_staged[i];
      end
      for (int unsigned j = 0; j < RegROCount; j++) begin
         if (csr_req_addr_i == RegAddrWidth'(RegRWCount + j))
            w_rd_data = csr_reg_ro_set_i[j*RegDataWidth +: RegDataWidth];
      end
      if (csr_req_addr_i == RegAddrWidth'(LaunchAddr))
         w_rd_data = {{(RegDataWidth-1){1'b0}}, (r_state == ST_PEND)};
   end

   // Read response register, held until the core takes it
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
      end else if (w_rd) begin
         r_rsp_valid <= 1'b1;
         r_rsp_data  <= w_rd_data;
      end else if (csr_rsp_ready_i) begin
         r_rsp_valid <= 1'b0;
      end
   end

   // Flatten the committed set, word 0 in the low bits
   always_comb begin
      csr_reg_set_o = '0;
      for (int unsigned i = 0; i < RegRWCount; i++)
         csr_reg_set_o[i*RegDataWidth +: RegDataWidth] = r_commit[i];
   end

   assign csr_req_ready_o     = w_req_ready;
   assign csr_rsp_valid_o     = r_rsp_valid;
   assign csr_rsp_data_o      = r_rsp_data;
   assign csr_reg_set_valid_o = w_set_valid;

endmodule
